gear_shift_sequencer: RTL and testbench
=======================================

Name: gear_shift_sequencer

Overview:
- Controller that sequences the transmission gear state.
- Accepts raw lever switches {P,R,N,D}, the brake and vehicle speed.
- Debounces lever requests and enforces safety interlocks.
- In Drive, schedules automatic D1..D4 shifts with hysteresis and a minimum dwell time.
- Drives the 7-bit gear LED bus {R1,N1,P1,D4,D3,D2,D1} that the board top-level displays.

Parameters:
DEB_CYC, 4, consecutive cycles a lever value must be stable before it is accepted (1..15)
DWELL_CYC, 16, minimum cycles after any gear change before the next change (1..255)
UP1, 40, speed threshold for the D1->D2 upshift
UP2, 70, speed threshold for the D2->D3 upshift
UP3, 100, speed threshold for the D3->D4 upshift
HYST, 8, downshift hysteresis; requires UPk > HYST

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
lever  input  4  {P,R,N,D} raw switches
brake  input  1  brake pedal, 1 = pressed
speed  input  8  unsigned vehicle speed
gear_led  output  7  {R1,N1,P1,D4,D3,D2,D1}, exactly one bit set, registered
shift_pulse  output  1  one-cycle pulse in the cycle gear_led changes
reject  output  1  one-cycle pulse when an accepted lever request violates an interlock
busy  output  1  dwell counter nonzero

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state PARK; gear_led = 7'b0010000; shift_pulse = reject = busy = 0; debounce counter, dwell counter and pending request all 0.
- Lever decode: valid only if exactly one lever bit is set. Invalid values (0000, or two or more bits) clear the debounce counter; they produce no request and no reject.
- Debounce: a valid value held identical for DEB_CYC consecutive cycles becomes the pending request, once per stable run. The value must change before the same value can re-trigger.
- States: PARK, REV, NEU, DRV (with gear index 1..4).
- Interlocks, checked when a request is applied:
  - Leaving PARK requires brake = 1.
  - Entering PARK or REV requires speed == 0.
  - Entering REV also requires brake = 1.
  - NEU is always allowed.
  - Entering DRV always starts at D1.
  - A request equal to the current state is dropped silently.
  - A violation pulses reject, keeps the state and clears the pending request.
- Dwell: while busy = 1, pending requests are held. The latest debounced value overwrites the older one. The request is applied in the first cycle busy = 0, with validity checked at apply time.
- Latency: gear_led updates on the clock edge after a request is applied, i.e. DEB_CYC+1 cycles after a stable lever with no dwell.
- Auto shift, in DRV only when busy = 0:
  - Upshift k->k+1 when speed >= UPk (k = 1..3).
  - Downshift k->k-1 when speed < UP(k-1) - HYST (k = 2..4).
  - One gear step per shift.
- Simultaneous events: an applied lever request has priority over an auto shift in the same cycle.
- Dwell timing: every gear_led change loads the dwell counter with DWELL_CYC and pulses shift_pulse. The counter decrements to 0 and busy = (counter != 0).
- Mid-operation reset: an asserted reset overrides everything that cycle and returns all outputs to reset values the next cycle.
- Width: speed is compared unsigned. The thresholds UPk - HYST are computed at elaboration time.

Optional Feature:
- Macro: KICKDOWN_EN.
- Defined:
  - Adds input port kickdown (1 bit), placed after speed.
  - In DRV with gear > 1 and busy = 0, a kickdown rising edge forces one downshift regardless of speed.
  - Upshifts are inhibited while kickdown stays high.
  - Normal dwell and shift_pulse rules apply.
- Undefined: no kickdown port; behaviour exactly as above.

Test Plan:
- Reset: assert reset for 2 cycles -> gear_led = 0010000, busy = 0, shift_pulse = 0.
- PARK->DRV with brake: brake = 1, speed = 0, lever = 0001 for 4 cycles -> gear_led = 0000001 next cycle, shift_pulse = 1, busy high for 16 cycles.
- Interlock reject: in DRV, speed = 20, lever = 0100 (R) held 4 cycles -> reject pulse, gear_led stays at D1; lever = 1000 (P) -> reject; lever = 0010 (N) -> gear_led = 0100000.
- Upshift/hysteresis: in D1, speed ramps 0->110 -> D2 at 40, D3 at 70, D4 at 100, each separated by at least 16 cycles. Speed drops to 93 -> stays D4; speed 91 -> D3.
- Dwell hold: request N 5 cycles after a shift -> no change until busy falls, then gear_led = 0100000 in the first non-busy cycle. Glitch 0011 mid-debounce -> counter restarts.
- With KICKDOWN_EN: in D3 at speed 80, busy = 0, kickdown rises -> D2 with shift_pulse; kickdown held with speed 120 -> no upshift until released.

Source files
------------

// File: rtl/gear_shift_sequencer.sv
// rtl/gear_shift_sequencer.sv - debounced lever, interlocks and D1..D4 auto-shift sequencer (optional KICKDOWN_EN)
module gear_shift_sequencer #(
  parameter int DEB_CYC   = 4,
  parameter int DWELL_CYC = 16,
  parameter int UP1       = 40,
  parameter int UP2       = 70,
  parameter int UP3       = 100,
  parameter int HYST      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] lever,
  input  logic       brake,
  input  logic [7:0] speed,
`ifdef KICKDOWN_EN
  input  logic       kickdown,
`endif
  output logic [6:0] gear_led,
  output logic       shift_pulse,
  output logic       reject,
  output logic       busy
);

  localparam logic [1:0] ST_PARK = 2'd0;
  localparam logic [1:0] ST_REV  = 2'd1;
  localparam logic [1:0] ST_NEU  = 2'd2;
  localparam logic [1:0] ST_DRV  = 2'd3;

  localparam logic [3:0] DEB_T   = 4'(DEB_CYC);
  localparam logic [7:0] DWELL_T = 8'(DWELL_CYC);
  localparam logic [7:0] UP1_T   = 8'(UP1);
  localparam logic [7:0] UP2_T   = 8'(UP2);
  localparam logic [7:0] UP3_T   = 8'(UP3);
  localparam logic [7:0] DN2_T   = 8'(UP1 - HYST);
  localparam logic [7:0] DN3_T   = 8'(UP2 - HYST);
  localparam logic [7:0] DN4_T   = 8'(UP3 - HYST);

  logic [1:0] state_q, state_d;
  logic [1:0] gidx_q, gidx_d;   // 0..3 stands for D1..D4
  logic [3:0] deb_val_q, deb_cnt_q, deb_cnt_d;
  logic       deb_fire;
  logic       pend_valid_q;
  logic [3:0] pend_val_q;
  logic [1:0] req_state;
  logic [7:0] dwell_q;
  logic [6:0] led_d;
  logic       reject_d;
  logic       led_change;
  logic       apply;
  logic       lever_ok;
  logic [7:0] up_thr, dn_thr;
  logic       kick_rise, up_allow;

  assign lever_ok = (lever != 4'd0) && ((lever & (lever - 4'd1)) == 4'd0);
  assign busy     = (dwell_q != 8'd0);
  assign apply    = pend_valid_q && !busy;

`ifdef KICKDOWN_EN
  logic kick_q;
  assign kick_rise = kickdown && !kick_q;
  assign up_allow  = !kickdown;

  // Previous kickdown level for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) kick_q <= 1'b0;
    else       kick_q <= kickdown;
  end
`else
  assign kick_rise = 1'b0;
  assign up_allow  = 1'b1;
`endif

  // Debounce: count identical valid samples, fire once when the run reaches DEB_CYC
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    deb_fire  = 1'b0;
    if (!lever_ok) begin
      deb_cnt_d = 4'd0;
    end else if (lever != deb_val_q) begin
      deb_cnt_d = 4'd1;
      deb_fire  = (DEB_T == 4'd1);
    end else if (deb_cnt_q != DEB_T) begin
      deb_cnt_d = deb_cnt_q + 4'd1;
      deb_fire  = ((deb_cnt_q + 4'd1) == DEB_T);
    end
  end

  // Map the one-hot pending lever code to a target state
  always_comb begin
    req_state = ST_PARK;
    case (pend_val_q)
      4'b0100: req_state = ST_REV;
      4'b0010: req_state = ST_NEU;
      4'b0001: req_state = ST_DRV;
      default: req_state = ST_PARK;
    endcase
  end

  // Shift thresholds for the current drive gear
  always_comb begin
    up_thr = 8'hFF;
    dn_thr = 8'd0;
    case (gidx_q)
      2'd0: up_thr = UP1_T;
      2'd1: begin up_thr = UP2_T; dn_thr = DN2_T; end
      2'd2: begin up_thr = UP3_T; dn_thr = DN3_T; end
      default: dn_thr = DN4_T;
    endcase
  end

  // Next state: lever request (with interlocks) wins over kickdown, which wins over auto shift
  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    reject_d = 1'b0;
    if (apply) begin
      if (req_state != state_q) begin
        if ((state_q == ST_PARK && !brake) ||
            (req_state == ST_PARK && speed != 8'd0) ||
            (req_state == ST_REV && (speed != 8'd0 || !brake))) begin
          reject_d = 1'b1;
        end else begin
          state_d = req_state;
          gidx_d  = 2'd0;
        end
      end
    end else if (state_q == ST_DRV && !busy) begin
      if (kick_rise && gidx_q != 2'd0)
        gidx_d = gidx_q - 2'd1;
      else if (up_allow && gidx_q != 2'd3 && speed >= up_thr)
        gidx_d = gidx_q + 2'd1;
      else if (gidx_q != 2'd0 && speed < dn_thr)
        gidx_d = gidx_q - 2'd1;
    end
  end

  // LED pattern {R1,N1,P1,D4,D3,D2,D1} for the next state
  always_comb begin
    led_d = 7'b0010000;
    case (state_d)
      ST_REV:  led_d = 7'b1000000;
      ST_NEU:  led_d = 7'b0100000;
      ST_DRV:  led_d = 7'b0000001 << gidx_d;
      default: led_d = 7'b0010000;
    endcase
  end

  assign led_change = (led_d != gear_led);

  // Registered state, outputs, dwell timer and pending request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PARK;
      gidx_q       <= 2'd0;
      deb_val_q    <= 4'd0;
      deb_cnt_q    <= 4'd0;
      pend_valid_q <= 1'b0;
      pend_val_q   <= 4'd0;
      dwell_q      <= 8'd0;
      gear_led     <= 7'b0010000;
      shift_pulse  <= 1'b0;
      reject       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      deb_cnt_q   <= deb_cnt_d;
      if (lever_ok) deb_val_q <= lever;
      // A fresh debounced value overwrites any request still held by dwell
      if (deb_fire) begin
        pend_valid_q <= 1'b1;
        pend_val_q   <= lever;
      end else if (apply) begin
        pend_valid_q <= 1'b0;
      end
      if (led_change)          dwell_q <= DWELL_T;
      else if (dwell_q != 8'd0) dwell_q <= dwell_q - 8'd1;
      gear_led    <= led_d;
      shift_pulse <= led_change;
      reject      <= reject_d;
    end
  end

endmodule

// File: tb/tb_gear_shift_sequencer.sv
// tb/tb_gear_shift_sequencer.sv - scoreboard bench for gear_shift_sequencer
module tb_gear_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] lever;
  logic       brake;
  logic [7:0] speed;
`ifdef KICKDOWN_EN
  logic       kickdown;
`endif
  logic [6:0] gear_led;
  logic       shift_pulse;
  logic       reject;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct packed {
    logic        rej;
    logic [6:0]  led;
    logic [31:0] at;
  } ev_t;

  ev_t exp_q[$];

  gear_shift_sequencer dut (
    .clk(clk),
    .reset(reset),
    .lever(lever),
    .brake(brake),
    .speed(speed),
`ifdef KICKDOWN_EN
    .kickdown(kickdown),
`endif
    .gear_led(gear_led),
    .shift_pulse(shift_pulse),
    .reject(reject),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every shift or reject pulse must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (!reset && (shift_pulse || reject)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got rej=%0d led=%b at cyc %0d, required no event",
                 reject, gear_led, cyc);
      end else begin
        e = exp_q.pop_front();
        if (reject !== e.rej || gear_led !== e.led || cyc !== int'(e.at)) begin
          miscompares++;
          $display("FAIL event: got rej=%0d led=%b at cyc %0d, required rej=%0d led=%b at cyc %0d",
                   reject, gear_led, cyc, e.rej, e.led, e.at);
        end
      end
    end
  end

  task automatic expect_ev(input logic rej, input logic [6:0] led, input int at);
    exp_q.push_back('{rej: rej, led: led, at: 32'(at)});
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, s, u;
    reset = 1'b1;
    lever = 4'b0000;
    brake = 1'b0;
    speed = 8'd0;
`ifdef KICKDOWN_EN
    kickdown = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_led", {1'b0, gear_led}, 8'b0001_0000);
    check("reset_busy", {7'd0, busy}, 8'd0);
    check("reset_shift", {7'd0, shift_pulse}, 8'd0);
    check("reset_reject", {7'd0, reject}, 8'd0);

    // PARK -> DRV with brake, then dwell length
    reset = 1'b0;
    t = cyc;
    brake = 1'b1;
    lever = 4'b0001;
    expect_ev(1'b0, 7'b0000001, t + 5);
    wait_until(t + 4);
    check("drv_latency_hold", {1'b0, gear_led}, 8'b0001_0000);
    wait_until(t + 5);
    check("busy_start", {7'd0, busy}, 8'd1);
    wait_until(t + 20);
    check("busy_last", {7'd0, busy}, 8'd1);
    wait_until(t + 21);
    check("busy_end", {7'd0, busy}, 8'd0);

    // Interlock rejects while moving, then neutral
    t = cyc;
    speed = 8'd20;
    lever = 4'b0100;
    expect_ev(1'b1, 7'b0000001, t + 5);
    wait_until(t + 6);
    t = cyc;
    lever = 4'b1000;
    expect_ev(1'b1, 7'b0000001, t + 5);
    wait_until(t + 6);
    check("after_rejects_led", {1'b0, gear_led}, 8'b0000_0001);
    t = cyc;
    lever = 4'b0010;
    expect_ev(1'b0, 7'b0100000, t + 5);
    wait_until(t + 21);

    // Back to D1, then ramp speed 0..110 one step per cycle
    t = cyc;
    speed = 8'd0;
    lever = 4'b0001;
    expect_ev(1'b0, 7'b0000001, t + 5);
    wait_until(t + 21);
    t = cyc;
    expect_ev(1'b0, 7'b0000010, t + 41);
    expect_ev(1'b0, 7'b0000100, t + 71);
    expect_ev(1'b0, 7'b0001000, t + 101);
    for (int i = 0; i <= 110; i++) begin
      speed = 8'(i);
      @(negedge clk);
    end
    wait_until(t + 118);

    // Hysteresis around the D4->D3 threshold of 92
    t = cyc;
    speed = 8'd93;
    wait_until(t + 20);
    check("hyst_hold_d4", {1'b0, gear_led}, 8'b0000_1000);
    t = cyc;
    speed = 8'd91;
    s = t + 1;
    expect_ev(1'b0, 7'b0000100, s);

    // Neutral request issued during dwell is held until busy falls
    wait_until(s + 5);
    lever = 4'b0010;
    expect_ev(1'b0, 7'b0100000, s + 17);
    wait_until(s + 10);
    check("dwell_hold_led", {1'b0, gear_led}, 8'b0000_0100);
    check("dwell_hold_busy", {7'd0, busy}, 8'd1);
    wait_until(s + 33);

    // Glitch 0011 mid-debounce restarts the count
    u = cyc;
    speed = 8'd0;
    lever = 4'b0001;
    wait_until(u + 2);
    lever = 4'b0011;
    wait_until(u + 3);
    lever = 4'b0001;
    expect_ev(1'b0, 7'b0000001, u + 8);
    wait_until(u + 7);
    check("glitch_hold_led", {1'b0, gear_led}, 8'b0010_0000);
    wait_until(u + 24);

`ifdef KICKDOWN_EN
    // Kickdown: D3 at 80 -> D2, upshift inhibited while held
    t = cyc;
    speed = 8'd80;
    expect_ev(1'b0, 7'b0000010, t + 1);
    expect_ev(1'b0, 7'b0000100, t + 18);
    wait_until(t + 40);
    kickdown = 1'b1;
    expect_ev(1'b0, 7'b0000010, t + 41);
    wait_until(t + 42);
    speed = 8'd120;
    wait_until(t + 80);
    check("kick_inhibit_led", {1'b0, gear_led}, 8'b0000_0010);
    kickdown = 1'b0;
    expect_ev(1'b0, 7'b0000100, t + 81);
    expect_ev(1'b0, 7'b0001000, t + 98);
    wait_until(t + 105);
`endif

    // Mid-operation reset while busy
    u = cyc;
    speed = 8'd0;
    lever = 4'b0000;
    brake = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_led", {1'b0, gear_led}, 8'b0001_0000);
    check("midreset_busy", {7'd0, busy}, 8'd0);
    check("midreset_shift", {7'd0, shift_pulse}, 8'd0);
    wait_until(u + 20);
    check("final_led", {1'b0, gear_led}, 8'b0001_0000);
    check("pending_events", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
